sram_read_sched: RTL and testbench

- Schedules burst reads from the shared single-port sram for two independent requesters (ch0, ch1).
- Each requester asks for LEN words starting at an address. The block arbitrates, drives the sram address/read-enable, and tags the returned data with the owning channel.
- It sits between the consumers (e.g. the input streamer) and the sram read port. It replaces ad-hoc free-running address counters.

---
 rtl/sram_read_sched_if.sv | 32 +++
 rtl/sram_read_sched.sv | 157 +++++++++++++++
 tb/tb_sram_read_sched.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_read_sched_if.sv
// Request, sram read port and return-path signals of the sram read scheduler.
// master: requesters plus sram model side; slave: the scheduler.
interface sram_read_sched_if #(
  parameter int MAX_ADDR  = 10,
  parameter int DATA_SIZE = 32,
  parameter int LEN_W     = 8
);
  logic [1:0]           req;
  logic [MAX_ADDR-1:0]  start_addr0;
  logic [MAX_ADDR-1:0]  start_addr1;
  logic [LEN_W-1:0]     len0;
  logic [LEN_W-1:0]     len1;
  logic                 ready;
  logic [MAX_ADDR-1:0]  sram_addr;
  logic                 sram_re_en;
  logic [DATA_SIZE-1:0] sram_data;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 id_out;
  logic [1:0]           grant;
  logic [1:0]           done;

  modport master (
    output req, start_addr0, start_addr1, len0, len1, ready, sram_data,
    input  sram_addr, sram_re_en, data_out, valid_out, id_out, grant, done
  );

  modport slave (
    input  req, start_addr0, start_addr1, len0, len1, ready, sram_data,
    output sram_addr, sram_re_en, data_out, valid_out, id_out, grant, done
  );
endinterface

// File: rtl/sram_read_sched.sv
// Two-channel burst read scheduler for the shared single-port sram.
// Define ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (ch0 first).
//
// state   | meaning
// IDLE    | waiting for a request; arbitrates and captures start address / length
// READ    | issuing one sram read per cycle while ready is high
// DRAIN   | waiting SRAM_LAT cycles for in-flight data, then pulses done
module sram_read_sched #(
  parameter int MAX_ADDR      = 10,
  parameter int DATA_SIZE     = 32,
  parameter int MAX_LOCATIONS = 1024,
  parameter int LEN_W         = 8,
  parameter int SRAM_LAT      = 1
) (
  input logic         pulse,
  input logic         rst,
  sram_read_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t               state, state_nx;
  logic [MAX_ADDR-1:0]  addr, addr_nx, addr_inc;
  logic [MAX_ADDR-1:0]  sram_addr_r, sram_addr_nx;
  logic [LEN_W-1:0]     remaining, remaining_nx;
  logic                 owner, owner_nx;
  logic [1:0]           drain_cnt, drain_cnt_nx;
  logic                 re_en_r, re_en_nx;
  logic [1:0]           grant_r, grant_nx;
  logic [1:0]           done_r, done_nx;
  logic [SRAM_LAT-1:0]  vld_pipe, id_pipe;
  logic                 win;
  logic [MAX_ADDR-1:0]  win_addr;
  logic [LEN_W-1:0]     win_len;
  logic [DATA_SIZE-1:0] rd_word;

`ifdef ROUND_ROBIN_EN
  logic rr_ptr, rr_nx;
  assign win = (bus.req == 2'b11) ? rr_ptr : bus.req[1];
`else
  assign win = ~bus.req[0];
`endif

  assign win_addr = win ? bus.start_addr1 : bus.start_addr0;
  assign win_len  = win ? bus.len1 : bus.len0;
  assign addr_inc = (addr == MAX_ADDR'(MAX_LOCATIONS - 1)) ? '0 : addr + 1'b1;

  always_comb begin
    state_nx     = state;
    addr_nx      = addr;
    remaining_nx = remaining;
    owner_nx     = owner;
    drain_cnt_nx = drain_cnt;
    sram_addr_nx = sram_addr_r;
    re_en_nx     = 1'b0;
    grant_nx     = grant_r;
    done_nx      = 2'b00;
`ifdef ROUND_ROBIN_EN
    rr_nx        = rr_ptr;
`endif
    case (state)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          owner_nx     = win;
          addr_nx      = win_addr;
          remaining_nx = win_len;
          if (win_len != '0) begin
            grant_nx = win ? 2'b10 : 2'b01;
            state_nx = S_READ;
          end else begin
            // zero-length burst completes at once without touching the sram
            done_nx = win ? 2'b10 : 2'b01;
`ifdef ROUND_ROBIN_EN
            rr_nx   = ~win;
`endif
          end
        end
      end
      S_READ: begin
        if (bus.ready) begin
          re_en_nx     = 1'b1;
          sram_addr_nx = addr;
          addr_nx      = addr_inc;
          remaining_nx = remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            state_nx     = S_DRAIN;
            drain_cnt_nx = 2'(SRAM_LAT - 1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt == 2'd0) begin
          done_nx  = owner ? 2'b10 : 2'b01;
          grant_nx = 2'b00;
          state_nx = S_IDLE;
`ifdef ROUND_ROBIN_EN
          rr_nx    = ~owner;
`endif
        end else begin
          drain_cnt_nx = drain_cnt - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pulse or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      addr        <= '0;
      remaining   <= '0;
      owner       <= 1'b0;
      drain_cnt   <= 2'd0;
      sram_addr_r <= '0;
      re_en_r     <= 1'b0;
      grant_r     <= 2'b00;
      done_r      <= 2'b00;
`ifdef ROUND_ROBIN_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      addr        <= addr_nx;
      remaining   <= remaining_nx;
      owner       <= owner_nx;
      drain_cnt   <= drain_cnt_nx;
      sram_addr_r <= sram_addr_nx;
      re_en_r     <= re_en_nx;
      grant_r     <= grant_nx;
      done_r      <= done_nx;
`ifdef ROUND_ROBIN_EN
      rr_ptr      <= rr_nx;
`endif
    end
  end

  // Return-path strobe and tag trail the issue by exactly SRAM_LAT cycles.
  always_ff @(posedge pulse or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= SRAM_LAT'({vld_pipe, re_en_r});
      id_pipe  <= SRAM_LAT'({id_pipe, owner});
    end
  end

  assign rd_word        = bus.sram_data;
  assign bus.data_out   = rd_word;
  assign bus.sram_addr  = sram_addr_r;
  assign bus.sram_re_en = re_en_r;
  assign bus.valid_out  = vld_pipe[SRAM_LAT-1];
  assign bus.id_out     = id_pipe[SRAM_LAT-1];
  assign bus.grant      = grant_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_sram_read_sched.sv
// Randomized bench for sram_read_sched: sram model, transaction-level arbitration model
// and a scoreboard of issued addresses, returned beats and done pulses.
module tb_sram_read_sched;
  localparam int MAX_ADDR  = 10;
  localparam int DATA_SIZE = 32;
  localparam int MAX_LOC   = 1024;
  localparam int LEN_W     = 8;
  localparam int SRAM_LAT  = 1;

  logic pulse = 1'b0;
  logic rst   = 1'b0;
  always #5 pulse = ~pulse;

  sram_read_sched_if #(.MAX_ADDR(MAX_ADDR), .DATA_SIZE(DATA_SIZE), .LEN_W(LEN_W)) bus ();

  sram_read_sched #(
    .MAX_ADDR(MAX_ADDR), .DATA_SIZE(DATA_SIZE), .MAX_LOCATIONS(MAX_LOC),
    .LEN_W(LEN_W), .SRAM_LAT(SRAM_LAT)
  ) dut (
    .pulse(pulse),
    .rst  (rst),
    .bus  (bus.slave)
  );

  // sram model: data for a read appears SRAM_LAT cycles after re_en
  logic [DATA_SIZE-1:0] mem [MAX_LOC];
  logic [DATA_SIZE-1:0] rd_stage [SRAM_LAT];
  always @(posedge pulse) begin
    if (bus.sram_re_en) rd_stage[0] <= mem[bus.sram_addr];
    for (int i = 1; i < SRAM_LAT; i++) rd_stage[i] <= rd_stage[i-1];
  end
  assign bus.sram_data = rd_stage[SRAM_LAT-1];

  // monitor
  int cyc = 0;
  logic rdy_q = 1'b0;
  int obs_addr[$];
  logic [DATA_SIZE-1:0] obs_data[$];
  int obs_id[$];
  int obs_vcyc[$];
  int obs_done[$];
  int viol = 0;

  always @(posedge pulse) begin
    cyc   <= cyc + 1;
    rdy_q <= bus.ready;
  end

  always @(negedge pulse) begin
    if (rst) begin
      if (bus.sram_re_en) begin
        obs_addr.push_back(int'(bus.sram_addr));
        if (!rdy_q) viol++;
      end
      if (bus.valid_out) begin
        obs_data.push_back(bus.data_out);
        obs_id.push_back(int'(bus.id_out));
        obs_vcyc.push_back(cyc);
      end
      if (bus.done[0]) obs_done.push_back(0);
      if (bus.done[1]) obs_done.push_back(1);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: order of bursts and the words each one must return
  int exp_addr[$];
  int exp_id[$];
  int exp_order[$];
`ifdef ROUND_ROBIN_EN
  int m_rr = 0;
`endif
  int last_n0;
  int last_bd;

  task automatic plan(input logic [1:0] rq, input int nb, input bit drop);
    logic [1:0] pending;
    int w, st, ln;
    pending = rq;
    exp_addr.delete();
    exp_id.delete();
    exp_order.delete();
    for (int k = 0; k < nb && pending != 2'b00; k++) begin
      if (pending == 2'b11) begin
`ifdef ROUND_ROBIN_EN
        w = m_rr;
`else
        w = 0;
`endif
      end else begin
        w = pending[1] ? 1 : 0;
      end
      exp_order.push_back(w);
      st = (w == 1) ? int'(bus.start_addr1) : int'(bus.start_addr0);
      ln = (w == 1) ? int'(bus.len1) : int'(bus.len0);
      for (int i = 0; i < ln; i++) begin
        exp_addr.push_back((st + i) % MAX_LOC);
        exp_id.push_back(w);
      end
`ifdef ROUND_ROBIN_EN
      m_rr = 1 - w;
`endif
      if (drop) pending[w] = 1'b0;
    end
  endtask

  // rmode: 0 ready held high, 1 random ready, 2 fixed toggle pattern
  task automatic run(input logic [1:0] rq, input int nb, input bit drop,
                     input bit scram, input int rmode);
    int ba, bd, bo, got, ri, na, nd;
    bit gseen;
    logic [7:0] pat;
    pat = 8'b1111_1001;  // bit 0 first: 1,0,0,1,1,1,1,1
    ba = obs_addr.size();
    bd = obs_data.size();
    bo = obs_done.size();
    plan(rq, nb, drop);
    @(negedge pulse);
    bus.req   = rq;
    bus.ready = 1'b1;
    last_n0   = cyc;
    last_bd   = bd;
    got = 0; ri = 0; gseen = 1'b0;
    for (int t = 0; t < 2000 && got < nb; t++) begin
      @(negedge pulse);
      if (bus.done[0]) begin got++; if (drop) bus.req[0] = 1'b0; end
      if (bus.done[1]) begin got++; if (drop) bus.req[1] = 1'b0; end
      if (got >= nb) bus.req = 2'b00;
      if (scram && !gseen && bus.grant != 2'b00) begin
        gseen = 1'b1;
        bus.req = 2'b00;
        bus.start_addr0 = MAX_ADDR'($urandom_range(0, MAX_LOC - 1));
        bus.start_addr1 = MAX_ADDR'($urandom_range(0, MAX_LOC - 1));
        bus.len0 = LEN_W'($urandom_range(0, 20));
        bus.len1 = LEN_W'($urandom_range(0, 20));
      end
      case (rmode)
        1:       bus.ready = 1'($urandom_range(0, 1));
        2:       bus.ready = (ri < 8) ? pat[ri] : 1'b1;
        default: bus.ready = 1'b1;
      endcase
      ri++;
    end
    if (got < nb) chk("done_timeout", got, nb);
    bus.req   = 2'b00;
    bus.ready = 1'b1;
    repeat (SRAM_LAT + 4) @(negedge pulse);
    na = obs_addr.size() - ba;
    nd = obs_data.size() - bd;
    chk("issues", na, exp_addr.size());
    chk("beats", nd, exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < na) chk("addr", obs_addr[ba+i], exp_addr[i]);
      if (i < nd) begin
        chk("data", obs_data[bd+i], mem[exp_addr[i]]);
        chk("id", obs_id[bd+i], exp_id[i]);
      end
    end
    chk("ndone", obs_done.size() - bo, exp_order.size());
    for (int i = 0; i < exp_order.size() && bo + i < obs_done.size(); i++)
      chk("done_ch", obs_done[bo+i], exp_order[i]);
    chk("grant_idle", bus.grant, 0);
    chk("ready_viol", viol, 0);
  endtask

  initial begin
    int iss, ch, bd, bo;
    for (int i = 0; i < MAX_LOC; i++) mem[i] = $urandom;
    for (int i = 0; i < SRAM_LAT; i++) rd_stage[i] = '0;
    bus.req = 2'b00;
    bus.ready = 1'b1;
    bus.start_addr0 = '0;
    bus.start_addr1 = '0;
    bus.len0 = '0;
    bus.len1 = '0;

    #12;
    chk("rst_addr", bus.sram_addr, 0);
    chk("rst_re_en", bus.sram_re_en, 0);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_id", bus.id_out, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_done", bus.done, 0);
    @(negedge pulse);
    rst = 1'b1;
    repeat (2) @(negedge pulse);

    // basic burst with first-beat latency
    bus.start_addr0 = 10'd5;
    bus.len0 = 8'd4;
    run(2'b01, 1, 1'b1, 1'b0, 0);
    if (obs_vcyc.size() > last_bd) chk("latency", obs_vcyc[last_bd] - last_n0, 2 + SRAM_LAT);
    else chk("latency_beat", obs_vcyc.size(), last_bd + 1);

    // address wrap
    bus.start_addr1 = 10'd1022;
    bus.len1 = 8'd4;
    run(2'b10, 1, 1'b1, 1'b0, 0);

    // both requesting continuously
    bus.start_addr0 = 10'd100;
    bus.start_addr1 = 10'd200;
    bus.len0 = 8'd2;
    bus.len1 = 8'd2;
    run(2'b11, 3, 1'b0, 1'b0, 0);

    // ready back-pressure pattern
    bus.start_addr0 = 10'd300;
    bus.len0 = 8'd6;
    run(2'b01, 1, 1'b1, 1'b0, 2);

    // zero-length burst alongside a pending ch1
    bus.len0 = 8'd0;
    bus.start_addr1 = 10'd50;
    bus.len1 = 8'd3;
    run(2'b11, 2, 1'b1, 1'b0, 0);

    // random single-channel bursts; inputs scrambled after grant
    for (int k = 0; k < 14; k++) begin
      ch = $urandom_range(0, 1);
      if (ch == 1) begin
        bus.start_addr1 = MAX_ADDR'($urandom_range(0, MAX_LOC - 1));
        bus.len1 = LEN_W'($urandom_range(0, 12));
      end else begin
        bus.start_addr0 = MAX_ADDR'($urandom_range(0, MAX_LOC - 1));
        bus.len0 = LEN_W'($urandom_range(0, 12));
      end
      run((ch == 1) ? 2'b10 : 2'b01, 1, 1'b1, 1'b1, $urandom_range(0, 1));
    end

    // random two-channel contention
    for (int k = 0; k < 4; k++) begin
      bus.start_addr0 = MAX_ADDR'($urandom_range(0, MAX_LOC - 1));
      bus.start_addr1 = MAX_ADDR'($urandom_range(0, MAX_LOC - 1));
      bus.len0 = LEN_W'($urandom_range(1, 6));
      bus.len1 = LEN_W'($urandom_range(1, 6));
      run(2'b11, 2, 1'b1, 1'b0, $urandom_range(0, 1));
    end

    // reset during the third issue of an 8-word burst
    bus.start_addr0 = 10'd400;
    bus.len0 = 8'd8;
    @(negedge pulse);
    bus.req = 2'b01;
    bus.ready = 1'b1;
    iss = 0;
    for (int t = 0; t < 50 && iss < 3; t++) begin
      @(negedge pulse);
      if (bus.sram_re_en) iss++;
    end
    chk("rst_mid_issue", iss, 3);
    rst = 1'b0;
    bus.req = 2'b00;
    #1;
    chk("mid_rst_re_en", bus.sram_re_en, 0);
    chk("mid_rst_valid", bus.valid_out, 0);
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_addr", bus.sram_addr, 0);
    chk("mid_rst_id", bus.id_out, 0);
`ifdef ROUND_ROBIN_EN
    m_rr = 0;
`endif
    repeat (3) @(negedge pulse);
    rst = 1'b1;
    bd = obs_data.size();
    bo = obs_done.size();
    repeat (12) @(negedge pulse);
    chk("post_rst_beats", obs_data.size() - bd, 0);
    chk("post_rst_done", obs_done.size() - bo, 0);

    // normal operation resumes after reset
    bus.start_addr0 = 10'd1020;
    bus.len0 = 8'd7;
    run(2'b01, 1, 1'b1, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
